// File: rtl/otter_pipe_pkg.sv
// Shared types and helpers for the OTTER pipeline hazard/forwarding controller.
package otter_pipe_pkg;

    // Widest register address the shadow registers carry.
    localparam int RA_MAX = 5;

    typedef enum logic [1:0] {
        REG   = 2'd0,
        EXMEM = 2'd1,
        WB    = 2'd2,
        HOLD  = 2'd3
    } fwd_sel_t;

    typedef struct packed {
        logic [RA_MAX-1:0] rd;
        logic              reg_write;
        logic              mem_read;
        logic              valid;
    } stage_ctl_t;

    // A stage produces the register a consumer reads; x0 never matches.
    function automatic logic producer_match(input logic              valid,
                                            input logic              reg_write,
                                            input logic [RA_MAX-1:0] rd,
                                            input logic [RA_MAX-1:0] rs,
                                            input logic              used);
        return valid && reg_write && (rd != '0) && (rd == rs) && used;
    endfunction

endpackage

// File: rtl/otter_pipe_ctrl_fwd_select.sv
// Per-operand forwarding priority: youngest producer wins (MEM, then WB, then hold).
module otter_fwd_select
    import otter_pipe_pkg::*;
(
    input  logic [RA_MAX-1:0] rs_i,
    input  logic              rs_used_i,
    input  logic              mem_valid_i,
    input  logic              mem_reg_write_i,
    input  logic              mem_mem_read_i,
    input  logic [RA_MAX-1:0] mem_rd_i,
    input  logic              wb_valid_i,
    input  logic              wb_reg_write_i,
    input  logic [RA_MAX-1:0] wb_rd_i,
    input  logic [RA_MAX-1:0] hold_rd_i,
    output logic [1:0]        sel_o
);

    fwd_sel_t sel;

    // Load data in MEM is not available yet; the load-use stall keeps that case away.
    always_comb begin
        sel = REG;
        if (producer_match(mem_valid_i, mem_reg_write_i, mem_rd_i, rs_i, rs_used_i) && !mem_mem_read_i)
            sel = EXMEM;
        else if (producer_match(wb_valid_i, wb_reg_write_i, wb_rd_i, rs_i, rs_used_i))
            sel = WB;
        else if (producer_match(1'b1, 1'b1, hold_rd_i, rs_i, rs_used_i))
            sel = HOLD;
    end

    assign sel_o = sel;

endmodule

// File: rtl/otter_pipe_ctrl.sv
// Hazard, forwarding and valid-bit controller for the 5-stage OTTER pipeline.
module otter_pipe_ctrl
    import otter_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter int FWD_EN = 1
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [RA_W-1:0] de_rs1_i,
    input  logic [RA_W-1:0] de_rs2_i,
    input  logic            de_rs1_used_i,
    input  logic            de_rs2_used_i,
    input  logic [RA_W-1:0] de_rd_i,
    input  logic            de_reg_write_i,
    input  logic            de_mem_read_i,
    input  logic            ex_branch_taken_i,
    input  logic            mem_busy_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            stall_pc_o,
    output logic            stall_if_o,
    output logic            stall_de_o,
    output logic            stall_ex_o,
    output logic            stall_mem_o,
    output logic            if_de_valid_o,
    output logic            de_ex_valid_o,
    output logic            ex_mem_valid_o,
    output logic            mem_wb_valid_o,
    output logic [1:0]      fwd_a_sel_o,
    output logic [1:0]      fwd_b_sel_o,
    output logic [XLEN-1:0] hold_data_o,
    output logic [XLEN-1:0] stall_count_o,
    output logic [XLEN-1:0] flush_count_o
);

    stage_ctl_t        ex_q, ex_d, mem_q, mem_d;
    logic [RA_MAX-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
    logic              ex_rs1_used_q, ex_rs1_used_d, ex_rs2_used_q, ex_rs2_used_d;
    logic [RA_MAX-1:0] wb_rd_q, wb_rd_d;
    logic              wb_rw_q, wb_rw_d, wb_valid_q, wb_valid_d;
    logic              if_de_valid_q, if_de_valid_d;
    logic [RA_MAX-1:0] hold_rd_q, hold_rd_d;
    logic [XLEN-1:0]   hold_data_q, hold_data_d;
    logic [XLEN-1:0]   stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic [RA_MAX-1:0] de_rs1, de_rs2;
    logic              ex_m, mem_m, wb_m, hazard, flush, stall_front;
    logic [1:0]        sel_a, sel_b;

    assign de_rs1 = RA_MAX'(de_rs1_i);
    assign de_rs2 = RA_MAX'(de_rs2_i);

    // Which downstream stages produce a register the DE instruction reads.
    always_comb begin
        ex_m  = producer_match(ex_q.valid, ex_q.reg_write, ex_q.rd, de_rs1, de_rs1_used_i) ||
                producer_match(ex_q.valid, ex_q.reg_write, ex_q.rd, de_rs2, de_rs2_used_i);
        mem_m = producer_match(mem_q.valid, mem_q.reg_write, mem_q.rd, de_rs1, de_rs1_used_i) ||
                producer_match(mem_q.valid, mem_q.reg_write, mem_q.rd, de_rs2, de_rs2_used_i);
        wb_m  = producer_match(wb_valid_q, wb_rw_q, wb_rd_q, de_rs1, de_rs1_used_i) ||
                producer_match(wb_valid_q, wb_rw_q, wb_rd_q, de_rs2, de_rs2_used_i);
        hazard      = (FWD_EN != 0) ? (ex_m && ex_q.mem_read) : (ex_m || mem_m || wb_m);
        // EX is frozen during a memory wait, so its redirect is not acted on.
        flush       = ex_branch_taken_i && ex_q.valid && !mem_busy_i;
        stall_front = mem_busy_i || (hazard && !flush);
    end

    // Next state for valids, shadows, hold register and counters.
    always_comb begin
        ex_d          = ex_q;
        ex_rs1_d      = ex_rs1_q;
        ex_rs2_d      = ex_rs2_q;
        ex_rs1_used_d = ex_rs1_used_q;
        ex_rs2_used_d = ex_rs2_used_q;
        mem_d         = mem_q;
        wb_rd_d       = wb_rd_q;
        wb_rw_d       = wb_rw_q;
        wb_valid_d    = wb_valid_q;
        if_de_valid_d = if_de_valid_q;
        if (mem_busy_i) begin
            wb_valid_d = 1'b0;
            wb_rw_d    = 1'b0;
            wb_rd_d    = '0;
        end else begin
            wb_rd_d    = mem_q.rd;
            wb_rw_d    = mem_q.reg_write;
            wb_valid_d = mem_q.valid;
            mem_d      = ex_q;
            if (flush || hazard) begin
                ex_d          = '0;
                ex_rs1_d      = '0;
                ex_rs2_d      = '0;
                ex_rs1_used_d = 1'b0;
                ex_rs2_used_d = 1'b0;
            end else begin
                ex_d.rd        = RA_MAX'(de_rd_i);
                ex_d.reg_write = de_reg_write_i;
                ex_d.mem_read  = de_mem_read_i;
                ex_d.valid     = if_de_valid_q;
                ex_rs1_d       = de_rs1;
                ex_rs2_d       = de_rs2;
                ex_rs1_used_d  = de_rs1_used_i;
                ex_rs2_used_d  = de_rs2_used_i;
            end
            if (flush)       if_de_valid_d = 1'b0;
            else if (!hazard) if_de_valid_d = 1'b1;
        end
        hold_data_d = hold_data_q;
        hold_rd_d   = '0;
        if (wb_valid_q && wb_rw_q) begin
            hold_rd_d   = wb_rd_q;
            hold_data_d = wb_data_i;
        end
        stall_cnt_d = stall_cnt_q + XLEN'(stall_front);
        flush_cnt_d = flush_cnt_q + XLEN'(flush);
    end

    // State registers; synchronous reset overrides any stall or flush.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ex_q          <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rs1_used_q <= 1'b0;
            ex_rs2_used_q <= 1'b0;
            mem_q         <= '0;
            wb_rd_q       <= '0;
            wb_rw_q       <= 1'b0;
            wb_valid_q    <= 1'b0;
            if_de_valid_q <= 1'b0;
            hold_rd_q     <= '0;
            hold_data_q   <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            ex_q          <= ex_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_rs1_used_q <= ex_rs1_used_d;
            ex_rs2_used_q <= ex_rs2_used_d;
            mem_q         <= mem_d;
            wb_rd_q       <= wb_rd_d;
            wb_rw_q       <= wb_rw_d;
            wb_valid_q    <= wb_valid_d;
            if_de_valid_q <= if_de_valid_d;
            hold_rd_q     <= hold_rd_d;
            hold_data_q   <= hold_data_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    otter_fwd_select u_fwd_a (
        .rs_i(ex_rs1_q), .rs_used_i(ex_rs1_used_q),
        .mem_valid_i(mem_q.valid), .mem_reg_write_i(mem_q.reg_write),
        .mem_mem_read_i(mem_q.mem_read), .mem_rd_i(mem_q.rd),
        .wb_valid_i(wb_valid_q), .wb_reg_write_i(wb_rw_q), .wb_rd_i(wb_rd_q),
        .hold_rd_i(hold_rd_q), .sel_o(sel_a)
    );

    otter_fwd_select u_fwd_b (
        .rs_i(ex_rs2_q), .rs_used_i(ex_rs2_used_q),
        .mem_valid_i(mem_q.valid), .mem_reg_write_i(mem_q.reg_write),
        .mem_mem_read_i(mem_q.mem_read), .mem_rd_i(mem_q.rd),
        .wb_valid_i(wb_valid_q), .wb_reg_write_i(wb_rw_q), .wb_rd_i(wb_rd_q),
        .hold_rd_i(hold_rd_q), .sel_o(sel_b)
    );

    assign fwd_a_sel_o    = (FWD_EN != 0) ? sel_a : 2'd0;
    assign fwd_b_sel_o    = (FWD_EN != 0) ? sel_b : 2'd0;
    assign stall_pc_o     = stall_front;
    assign stall_if_o     = stall_front;
    assign stall_de_o     = stall_front;
    assign stall_ex_o     = mem_busy_i;
    assign stall_mem_o    = mem_busy_i;
    assign if_de_valid_o  = if_de_valid_q;
    assign de_ex_valid_o  = ex_q.valid;
    assign ex_mem_valid_o = mem_q.valid;
    assign mem_wb_valid_o = wb_valid_q;
    assign hold_data_o    = hold_data_q;
    assign stall_count_o  = stall_cnt_q;
    assign flush_count_o  = flush_cnt_q;

endmodule

// File: tb/tb_otter_pipe_ctrl.sv
// Directed bench: one forwarding controller and one interlock-only controller on shared inputs.
module tb_otter_pipe_ctrl;

    logic        CLK, RESET;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, rw, mr, br, busy;
    logic [31:0] wbd;

    logic        d_spc, d_sif, d_sde, d_sex, d_smem, d_v0, d_v1, d_v2, d_v3;
    logic [1:0]  d_fa, d_fb;
    logic [31:0] d_hold, d_scnt, d_fcnt;
    logic        i_spc, i_sif, i_sde, i_sex, i_smem, i_v0, i_v1, i_v2, i_v3;
    logic [1:0]  i_fa, i_fb;
    logic [31:0] i_hold, i_scnt, i_fcnt;

    int n_chk = 0;
    int n_err = 0;

    otter_pipe_ctrl #(.XLEN(32), .RA_W(5), .FWD_EN(1)) u_dut (
        .CLK(CLK), .RESET(RESET),
        .de_rs1_i(rs1), .de_rs2_i(rs2), .de_rs1_used_i(u1), .de_rs2_used_i(u2),
        .de_rd_i(rd), .de_reg_write_i(rw), .de_mem_read_i(mr),
        .ex_branch_taken_i(br), .mem_busy_i(busy), .wb_data_i(wbd),
        .stall_pc_o(d_spc), .stall_if_o(d_sif), .stall_de_o(d_sde),
        .stall_ex_o(d_sex), .stall_mem_o(d_smem),
        .if_de_valid_o(d_v0), .de_ex_valid_o(d_v1), .ex_mem_valid_o(d_v2), .mem_wb_valid_o(d_v3),
        .fwd_a_sel_o(d_fa), .fwd_b_sel_o(d_fb), .hold_data_o(d_hold),
        .stall_count_o(d_scnt), .flush_count_o(d_fcnt)
    );

    otter_pipe_ctrl #(.XLEN(32), .RA_W(5), .FWD_EN(0)) u_il (
        .CLK(CLK), .RESET(RESET),
        .de_rs1_i(rs1), .de_rs2_i(rs2), .de_rs1_used_i(u1), .de_rs2_used_i(u2),
        .de_rd_i(rd), .de_reg_write_i(rw), .de_mem_read_i(mr),
        .ex_branch_taken_i(br), .mem_busy_i(busy), .wb_data_i(wbd),
        .stall_pc_o(i_spc), .stall_if_o(i_sif), .stall_de_o(i_sde),
        .stall_ex_o(i_sex), .stall_mem_o(i_smem),
        .if_de_valid_o(i_v0), .de_ex_valid_o(i_v1), .ex_mem_valid_o(i_v2), .mem_wb_valid_o(i_v3),
        .fwd_a_sel_o(i_fa), .fwd_b_sel_o(i_fb), .hold_data_o(i_hold),
        .stall_count_o(i_scnt), .flush_count_o(i_fcnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic de(input logic [4:0] a, input logic ua, input logic [4:0] b, input logic ub,
                      input logic [4:0] d, input logic w, input logic m);
        rs1 = a; u1 = ua; rs2 = b; u2 = ub; rd = d; rw = w; mr = m;
        #1;
    endtask

    task automatic nop();
        de(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        RESET = 1'b1; br = 1'b0; busy = 1'b0; wbd = '0;
        rs1 = '0; rs2 = '0; rd = '0; u1 = 0; u2 = 0; rw = 0; mr = 0;
        tick(); tick(); #1;
        // Reset state
        chk("rst_valids", {28'd0, d_v0, d_v1, d_v2, d_v3}, 32'h0);
        chk("rst_stalls", {27'd0, d_spc, d_sif, d_sde, d_sex, d_smem}, 32'h0);
        chk("rst_cnts", d_scnt | d_fcnt, 32'h0);
        chk("rst_hold", d_hold, 32'h0);
        chk("rst_fwd", {30'd0, d_fa | d_fb}, 32'h0);

        // Valid ramp after reset release
        RESET = 1'b0;
        tick(); chk("ramp1", {28'd0, d_v0, d_v1, d_v2, d_v3}, 32'b1000);
        tick(); chk("ramp2", {28'd0, d_v0, d_v1, d_v2, d_v3}, 32'b1100);
        tick(); chk("ramp3", {28'd0, d_v0, d_v1, d_v2, d_v3}, 32'b1110);
        tick(); chk("ramp4", {28'd0, d_v0, d_v1, d_v2, d_v3}, 32'b1111);

        // Back-to-back ALU dependency: add x5 ; sub x6,x5,x1
        de(5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        chk("alu_a_stall", {31'd0, d_sde}, 32'd0);
        tick();
        de(5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
        chk("alu_b_stall", {31'd0, d_sde}, 32'd0);
        tick(); nop();
        chk("alu_fwd_a", {30'd0, d_fa}, 32'd1);
        chk("alu_fwd_b", {30'd0, d_fb}, 32'd0);
        tick(); tick(); tick();

        // Load-use: lw x7 ; add x8,x7,x7
        de(5'd2, 1, 5'd0, 0, 5'd7, 1, 1);
        chk("lu_lw_stall", {31'd0, d_sde}, 32'd0);
        tick();
        de(5'd7, 1, 5'd7, 1, 5'd8, 1, 0);
        chk("lu_stall", {29'd0, d_spc, d_sif, d_sde}, 32'b111);
        chk("lu_stall_ex", {30'd0, d_sex, d_smem}, 32'b00);
        tick();
        chk("lu_bubble", {31'd0, d_v1}, 32'd0);
        chk("lu_nostall2", {31'd0, d_sde}, 32'd0);
        tick(); nop();
        wbd = 32'hCAFE0007; #1;
        chk("lu_ex_valid", {31'd0, d_v1}, 32'd1);
        chk("lu_fwd_a", {30'd0, d_fa}, 32'd2);
        chk("lu_fwd_b", {30'd0, d_fb}, 32'd2);
        chk("lu_scnt", d_scnt, 32'd1);
        tick();
        chk("lu_hold", d_hold, 32'hCAFE0007);
        tick(); tick(); tick();

        // WB/DE overlap through the hold register
        de(5'd1, 1, 5'd0, 0, 5'd9, 1, 0);  tick();
        de(5'd1, 1, 5'd0, 0, 5'd10, 1, 0); tick();
        de(5'd2, 1, 5'd0, 0, 5'd11, 1, 0); tick();
        de(5'd9, 1, 5'd3, 1, 5'd12, 1, 0);
        wbd = 32'h12345679; #1;
        chk("ov_stall", {31'd0, d_sde}, 32'd0);
        tick(); nop();
        wbd = 32'hAAAA000A; #1;
        chk("ov_fwd_a", {30'd0, d_fa}, 32'd3);
        chk("ov_fwd_b", {30'd0, d_fb}, 32'd0);
        chk("ov_hold", d_hold, 32'h12345679);
        tick(); tick(); tick(); tick();

        // Taken branch while a load-use stall is pending
        de(5'd2, 1, 5'd0, 0, 5'd7, 1, 1); tick();
        de(5'd7, 1, 5'd7, 1, 5'd8, 1, 0);
        br = 1'b1; #1;
        chk("br_nostall", {29'd0, d_spc, d_sif, d_sde}, 32'b000);
        tick(); br = 1'b0; nop();
        chk("br_valids", {28'd0, d_v0, d_v1, d_v2, d_v3}, 32'b0011);
        chk("br_fcnt", d_fcnt, 32'd1);
        chk("br_scnt", d_scnt, 32'd1);
        tick(); chk("br_refill1", {30'd0, d_v0, d_v1}, 32'b10);
        tick(); chk("br_refill2", {30'd0, d_v0, d_v1}, 32'b11);
        tick(); tick();

        // Memory wait for 3 cycles with a forwarded pair in EX/MEM
        de(5'd1, 1, 5'd0, 0, 5'd13, 1, 0); tick();
        de(5'd13, 1, 5'd0, 0, 5'd14, 1, 0); tick();
        nop();
        busy = 1'b1; br = 1'b1; #1;
        chk("mb_stalls1", {27'd0, d_spc, d_sif, d_sde, d_sex, d_smem}, 32'b11111);
        chk("mb_fwd1", {30'd0, d_fa}, 32'd1);
        tick(); br = 1'b0; #1;
        chk("mb_wb_bub1", {31'd0, d_v3}, 32'd0);
        chk("mb_stalls2", {27'd0, d_spc, d_sif, d_sde, d_sex, d_smem}, 32'b11111);
        chk("mb_br_ign", {29'd0, d_v0, d_v1, d_v2}, 32'b111);
        chk("mb_fcnt", d_fcnt, 32'd1);
        tick();
        chk("mb_wb_bub2", {31'd0, d_v3}, 32'd0);
        chk("mb_stalls3", {27'd0, d_spc, d_sif, d_sde, d_sex, d_smem}, 32'b11111);
        tick();
        chk("mb_wb_bub3", {31'd0, d_v3}, 32'd0);
        busy = 1'b0; #1;
        chk("mb_release", {27'd0, d_spc, d_sif, d_sde, d_sex, d_smem}, 32'b00000);
        chk("mb_fwd_held", {30'd0, d_fa}, 32'd1);
        chk("mb_scnt", d_scnt, 32'd4);
        tick();
        chk("mb_resume", {31'd0, d_v3}, 32'd1);
        wbd = 32'hBEEF000D; #1;
        tick();
        chk("mb_producer_wb", d_hold, 32'hBEEF000D);

        // Reset wins; then interlock-only controller with the ALU dependency
        RESET = 1'b1; nop(); tick();
        chk("rst2_valids", {28'd0, i_v0, i_v1, i_v2, i_v3}, 32'h0);
        chk("rst2_cnts", d_scnt | d_fcnt | i_scnt, 32'h0);
        RESET = 1'b0;
        tick(); tick(); tick(); tick();
        de(5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        chk("il_a_stall", {31'd0, i_sde}, 32'd0);
        tick();
        de(5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
        chk("il_stall_ex", {31'd0, i_sde}, 32'd1);
        chk("il_fwd_a0", {30'd0, i_fa}, 32'd0);
        tick(); chk("il_stall_mem", {31'd0, i_sde}, 32'd1);
        tick(); chk("il_stall_wb", {31'd0, i_sde}, 32'd1);
        tick(); chk("il_go", {31'd0, i_sde}, 32'd0);
        tick(); nop();
        chk("il_ex_valid", {31'd0, i_v1}, 32'd1);
        chk("il_fwd_a", {30'd0, i_fa}, 32'd0);
        chk("il_fwd_b", {30'd0, i_fb}, 32'd0);
        chk("il_scnt", i_scnt, 32'd3);
        tick(); tick(); tick();

        // x0 is never a hazard or a forwarding source
        de(5'd1, 1, 5'd0, 0, 5'd0, 1, 0);
        chk("x0_a_stall", {31'd0, i_sde}, 32'd0);
        tick();
        de(5'd0, 1, 5'd0, 1, 5'd1, 1, 0);
        chk("x0_il_stall", {31'd0, i_sde}, 32'd0);
        chk("x0_d_stall", {31'd0, d_sde}, 32'd0);
        tick(); nop();
        chk("x0_fwd", {30'd0, d_fa | d_fb}, 32'd0);
        chk("x0_il_scnt", i_scnt, 32'd3);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
